ram_bus_master: RTL and testbench

Bus initiator for the data-RAM port (`RAMaddr`/`RAMsel`/`RAMld`/`RAMdataIn`/`RAMdataOut`/`RAMclr`), i.e. the CPU-side end of the load/store interface that the memory/peripheral responder serves. It accepts single or burst read/write/clear commands over a valid/ready handshake and converts them into one bus access per beat. Read data is returned on a response handshake. It is used as a debug/test loader in place of, or alongside, the CPU load/store unit, so it can fill RAM, drive the hex display at address 1 and sample the buttons at address 0.

---
 rtl/ram_bus_pkg.sv | 22 ++
 rtl/ram_bus_master.sv | 149 ++++++++++++++
 tb/tb_ram_bus_master.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the data-RAM bus initiator.
// Bus widths, burst length width, well-known peripheral addresses and the FSM state encoding.
package ram_bus_pkg;

   localparam int RAM_ADDR_W = 12;
   localparam int RAM_DATA_W = 16;
   localparam int BURST_W    = 4;

   localparam logic [RAM_ADDR_W-1:0] ADDR_BUTTONS = 12'd0;
   localparam logic [RAM_ADDR_W-1:0] ADDR_HEX     = 12'd1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_WDATA,
      ST_WISSUE,
      ST_RISSUE,
      ST_RWAIT,
      ST_RRESP
   } state_t;

endpackage

// File: rtl/ram_bus_master.sv
// Burst read/write/clear initiator for the data-RAM bus: one bus access per beat,
// read beats returned over a valid/ready response handshake.
module ram_bus_master
   import ram_bus_pkg::*;
#(
   parameter int READ_LATENCY = 1
)
(
   input  logic                  clk,
   input  logic                  res,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic                  cmd_clr,
   input  logic [RAM_ADDR_W-1:0] cmd_addr,
   input  logic [BURST_W-1:0]    cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [RAM_DATA_W-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [RAM_DATA_W-1:0] rd_data,
   output logic                  rd_last,
   output logic                  busy,
   output logic [RAM_ADDR_W-1:0] RAMaddr,
   output logic [RAM_DATA_W-1:0] RAMdataIn,
   input  logic [RAM_DATA_W-1:0] RAMdataOut,
   output logic                  RAMsel,
   output logic                  RAMld,
   output logic                  RAMclr
);

   // RWAIT exits when the latency counter reaches this value.
   localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

   state_t                  state_reg,  state_next;
   logic [RAM_ADDR_W-1:0]   addr_reg,   addr_next;
   logic [BURST_W-1:0]      len_reg,    len_next;
   logic [BURST_W-1:0]      count_reg,  count_next;
   logic [RAM_DATA_W-1:0]   wdata_reg,  wdata_next;
   logic [RAM_DATA_W-1:0]   rdata_reg,  rdata_next;
   logic [2:0]              lat_reg,    lat_next;

   logic last_beat;
   assign last_beat = (count_reg == len_reg);

   always_ff @(posedge clk) begin
      if (res) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         len_reg   <= '0;
         count_reg <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
         lat_reg   <= '0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         len_reg   <= len_next;
         count_reg <= count_next;
         wdata_reg <= wdata_next;
         rdata_reg <= rdata_next;
         lat_reg   <= lat_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      len_next   = len_reg;
      count_next = count_reg;
      wdata_next = wdata_reg;
      rdata_next = rdata_reg;
      lat_next   = lat_reg;
      case (state_reg)
         ST_IDLE: begin
            if (cmd_valid) begin
               // A clear ignores the address/length fields, so the bus address is left untouched.
               if (cmd_clr) begin
                  state_next = ST_CLR;
               end else begin
                  addr_next  = cmd_addr;
                  len_next   = cmd_len;
                  count_next = '0;
                  state_next = cmd_write ? ST_WDATA : ST_RISSUE;
               end
            end
         end
         ST_CLR: begin
            state_next = ST_IDLE;
         end
         ST_WDATA: begin
            if (wr_valid) begin
               wdata_next = wr_data;
               state_next = ST_WISSUE;
            end
         end
         ST_WISSUE: begin
            if (last_beat) begin
               state_next = ST_IDLE;
            end else begin
               addr_next  = addr_reg + 12'd1;
               count_next = count_reg + 4'd1;
               state_next = ST_WDATA;
            end
         end
         ST_RISSUE: begin
            lat_next   = '0;
            state_next = ST_RWAIT;
         end
         ST_RWAIT: begin
            if (lat_reg == LAT_LAST) begin
               rdata_next = RAMdataOut;
               state_next = ST_RRESP;
            end else begin
               lat_next = lat_reg + 3'd1;
            end
         end
         ST_RRESP: begin
            if (rd_ready) begin
               if (last_beat) begin
                  state_next = ST_IDLE;
               end else begin
                  addr_next  = addr_reg + 12'd1;
                  count_next = count_reg + 4'd1;
                  state_next = ST_RISSUE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Every output is a decode of registered state, never of an input.
   assign cmd_ready = (state_reg == ST_IDLE);
   assign busy      = (state_reg != ST_IDLE);
   assign wr_ready  = (state_reg == ST_WDATA);
   assign rd_valid  = (state_reg == ST_RRESP);
   assign rd_last   = (state_reg == ST_RRESP) && last_beat;
   assign rd_data   = rdata_reg;
   assign RAMsel    = (state_reg == ST_WISSUE) || (state_reg == ST_RISSUE);
   assign RAMld     = (state_reg != ST_WISSUE);
   assign RAMclr    = (state_reg == ST_CLR);
   assign RAMaddr   = addr_reg;
   assign RAMdataIn = wdata_reg;

endmodule

// File: tb/tb_ram_bus_master.sv
// Randomized bench for ram_bus_master: two lanes (READ_LATENCY 1 and 3), each with a RAM
// responder and a transaction-level scoreboard of expected bus writes, read issues and beats.
module tb_ram_bus_master;
   import ram_bus_pkg::*;

   typedef struct packed {logic [11:0] a; logic [15:0] d;} wr_t;
   typedef struct packed {logic [15:0] d; logic last;} beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   bit lane_done [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         localparam int LAT = (gi == 0) ? 1 : 3;

         logic        res, cmd_valid, cmd_ready, cmd_write, cmd_clr;
         logic [11:0] cmd_addr;
         logic [3:0]  cmd_len;
         logic        wr_valid, wr_ready;
         logic [15:0] wr_data;
         logic        rd_valid, rd_ready, rd_last, busy;
         logic [15:0] rd_data;
         logic [11:0] ram_addr;
         logic [15:0] ram_din, ram_dout;
         logic        ram_sel, ram_ld, ram_clr;

         ram_bus_master #(.READ_LATENCY(LAT)) dut (
            .clk(clk), .res(res),
            .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
            .cmd_clr(cmd_clr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
            .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
            .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
            .busy(busy),
            .RAMaddr(ram_addr), .RAMdataIn(ram_din), .RAMdataOut(ram_dout),
            .RAMsel(ram_sel), .RAMld(ram_ld), .RAMclr(ram_clr)
         );

         // Responder: data is valid only in the cycle exactly LAT cycles after the issue cycle.
         bit [15:0]   rmem [4096];
         bit [4095:0] rwritten;
         logic [11:0] iaddr = '0;
         int          since = 0;
         always @(posedge clk) begin
            if (ram_sel && !ram_ld) begin
               rmem[ram_addr]     <= ram_din;
               rwritten[ram_addr] <= 1'b1;
            end
            if (ram_sel && ram_ld) begin
               iaddr <= ram_addr;
               since <= 1;
            end else if (since < 64) begin
               since <= since + 1;
            end
         end
         assign ram_dout = (since == LAT)
                           ? (rwritten[iaddr] ? rmem[iaddr] : ({4'h0, iaddr} + 16'h0100))
                           : (16'hDEAD ^ 16'(since));

         // Reference model: memory contents plus queues of expected transactions.
         bit [15:0]   mmem [4096];
         bit [4095:0] mwritten;
         wr_t         exp_wr[$];
         logic [11:0] exp_ra[$];
         beat_t       exp_beat[$];
         int          exp_clr = 0;

         function automatic logic [15:0] mexp(input logic [11:0] a);
            return mwritten[a] ? mmem[a] : ({4'h0, a} + 16'h0100);
         endfunction

         task automatic lchk(input string n, input logic [31:0] act, input logic [31:0] exp);
            chk($sformatf("lat%0d_%s", LAT, n), act, exp);
         endtask

         always @(negedge clk) begin
            wr_t   w;
            beat_t b;
            if (res === 1'b0) begin
               lchk("busy_vs_ready", busy, !cmd_ready);
               if (ram_sel && !ram_ld) begin
                  lchk("bus_wr_expected", exp_wr.size() != 0, 1'b1);
                  if (exp_wr.size() != 0) begin
                     w = exp_wr.pop_front();
                     lchk("bus_wr_addr", ram_addr, w.a);
                     lchk("bus_wr_data", ram_din, w.d);
                  end
               end
               if (ram_sel && ram_ld) begin
                  lchk("bus_rd_expected", exp_ra.size() != 0, 1'b1);
                  if (exp_ra.size() != 0) lchk("bus_rd_addr", ram_addr, exp_ra.pop_front());
               end
               if (ram_clr) begin
                  lchk("clr_without_sel", ram_sel, 1'b0);
                  lchk("clr_expected", exp_clr > 0, 1'b1);
                  if (exp_clr > 0) exp_clr--;
               end
               if (rd_valid) begin
                  lchk("beat_expected", exp_beat.size() != 0, 1'b1);
                  if (exp_beat.size() != 0) begin
                     b = exp_beat[0];
                     lchk("rd_data", rd_data, b.d);
                     lchk("rd_last", rd_last, b.last);
                     if (rd_ready) void'(exp_beat.pop_front());
                  end
               end
            end
         end

         task automatic tick();
            @(posedge clk);
            #1;
         endtask

         function automatic logic cond(input int w);
            case (w)
               0: return cmd_ready;
               1: return wr_ready;
               2: return rd_valid;
               default: return !busy;
            endcase
         endfunction

         task automatic wait_cond(input string n, input int w, output int k);
            k = 0;
            while (!cond(w) && k < 200) begin
               tick();
               k++;
            end
            lchk({n, "_timeout"}, cond(w), 1'b1);
         endtask

         task automatic check_reset(input string n);
            lchk({n, "_cmd_ready"}, cmd_ready, 1'b1);
            lchk({n, "_busy"}, busy, 1'b0);
            lchk({n, "_wr_ready"}, wr_ready, 1'b0);
            lchk({n, "_rd_valid"}, rd_valid, 1'b0);
            lchk({n, "_rd_last"}, rd_last, 1'b0);
            lchk({n, "_rd_data"}, rd_data, 16'h0);
            lchk({n, "_sel"}, ram_sel, 1'b0);
            lchk({n, "_ld"}, ram_ld, 1'b1);
            lchk({n, "_clr"}, ram_clr, 1'b0);
            lchk({n, "_addr"}, ram_addr, 12'h0);
            lchk({n, "_din"}, ram_din, 16'h0);
         endtask

         task automatic send_cmd(input logic w, input logic c, input logic [11:0] a, input logic [3:0] l);
            int k;
            wait_cond("cmd_ready", 0, k);
            cmd_valid = 1'b1; cmd_write = w; cmd_clr = c; cmd_addr = a; cmd_len = l;
            tick();
            cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_clr = 1'($urandom);
            cmd_addr = 12'($urandom); cmd_len = 4'($urandom);
         endtask

         task automatic do_write(input logic [11:0] a, input logic [3:0] l, input logic [15:0] d0,
                                 input bit rnd, input int max_gap);
            logic [15:0] d;
            logic [11:0] aa;
            int k;
            aa = a;
            send_cmd(1'b1, 1'b0, a, l);
            for (int i = 0; i <= int'(l); i++) begin
               d = rnd ? 16'($urandom) : d0 + 16'(i);
               exp_wr.push_back('{aa, d});
               mmem[aa] = d;
               mwritten[aa] = 1'b1;
               aa = aa + 12'd1;
               repeat ($urandom_range(max_gap, 0)) tick();
               wr_valid = 1'b1;
               wr_data  = d;
               wait_cond("wr_ready", 1, k);
               tick();
               wr_valid = 1'b0;
               wr_data  = 16'($urandom);
            end
         endtask

         // stall < 0: random 0..3 cycles; abort_at >= 0: reset during that beat's response.
         task automatic do_read(input logic [11:0] a, input logic [3:0] l, input int stall,
                                input int abort_at);
            logic [11:0] aa;
            int k;
            aa = a;
            for (int i = 0; i <= int'(l); i++) begin
               exp_ra.push_back(aa);
               exp_beat.push_back('{mexp(aa), (i == int'(l))});
               aa = aa + 12'd1;
            end
            send_cmd(1'b0, 1'b0, a, l);
            for (int i = 0; i <= int'(l); i++) begin
               wait_cond("rd_valid", 2, k);
               if (stall == 0) lchk(i == 0 ? "accept_to_rd_valid" : "beat_to_beat", k, 1 + LAT);
               if (i == abort_at) begin
                  res = 1'b1;
                  exp_ra.delete();
                  exp_beat.delete();
                  tick();
                  check_reset("mid_burst_reset");
                  res = 1'b0;
                  return;
               end
               repeat (stall < 0 ? $urandom_range(3, 0) : stall) begin
                  rd_ready = 1'b0;
                  tick();
               end
               rd_ready = 1'b1;
               tick();
               rd_ready = 1'b0;
            end
         endtask

         initial begin
            int k;
            int r;
            res = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_clr = 1'b0;
            cmd_addr = 12'h123; cmd_len = 4'h2;
            wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check_reset("reset");
            res = 1'b0;
            cmd_valid = 1'b0;
            lchk("model_buttons", mexp(ADDR_BUTTONS), 16'h0100);
            lchk("model_hex", mexp(ADDR_HEX), 16'h0101);
            lchk("model_0x013", mexp(12'h013), 16'h0113);

            // Single write
            do_write(12'h005, 4'd0, 16'hBEEF, 1'b0, 0);
            lchk("single_wr_sel", ram_sel, 1'b1);
            lchk("single_wr_ld", ram_ld, 1'b0);
            lchk("single_wr_addr", ram_addr, 12'h005);
            lchk("single_wr_din", ram_din, 16'hBEEF);
            tick();
            lchk("single_wr_busy_clear", busy, 1'b0);
            lchk("single_wr_sel_drop", ram_sel, 1'b0);
            lchk("single_wr_din_hold", ram_din, 16'hBEEF);

            // Burst read with a 5-cycle consumer stall on every beat
            do_read(12'h010, 4'd3, 5, -1);

            // Address wrap within a write burst, then read the three words back
            do_write(12'hFFE, 4'd2, 16'd1, 1'b0, 1);
            lchk("model_wrap_ffe", mexp(12'hFFE), 16'd1);
            lchk("model_wrap_000", mexp(12'h000), 16'd3);
            do_read(12'hFFE, 4'd2, 0, -1);

            // Clear with garbage address/length
            exp_clr = 1;
            send_cmd(1'b0, 1'b1, 12'($urandom), 4'hF);
            lchk("clr_pulse", ram_clr, 1'b1);
            lchk("clr_cmd_ready_low", cmd_ready, 1'b0);
            tick();
            lchk("clr_pulse_end", ram_clr, 1'b0);
            lchk("clr_cmd_ready_back", cmd_ready, 1'b1);
            lchk("clr_busy_drop", busy, 1'b0);

            // Exact sampling cycle of a single read
            do_read(12'h001, 4'd0, 0, -1);

            // Randomized mix
            for (int n = 0; n < 30; n++) begin
               r = $urandom_range(9, 0);
               if (r < 4) begin
                  do_write(12'($urandom), 4'($urandom_range(7, 0)), 16'h0, 1'b1, 2);
               end else if (r < 8) begin
                  do_read(12'($urandom), 4'($urandom_range(7, 0)), (r == 7) ? 0 : -1, -1);
               end else begin
                  exp_clr++;
                  send_cmd(1'b0, 1'b1, 12'($urandom), 4'($urandom));
               end
            end

            // Reset during the 4th response beat of a 16-beat read
            do_read(12'($urandom), 4'd15, 0, 3);
            repeat (2 * LAT + 10) begin
               tick();
               lchk("no_beat_after_reset", rd_valid, 1'b0);
            end

            wait_cond("final_idle", 3, k);
            tick();
            lchk("wr_queue_drained", exp_wr.size(), 0);
            lchk("rd_issue_queue_drained", exp_ra.size(), 0);
            lchk("beat_queue_drained", exp_beat.size(), 0);
            lchk("clr_drained", exp_clr, 0);
            lane_done[gi] = 1'b1;
         end
      end
   endgenerate

   initial begin
      int k;
      k = 0;
      while (!(lane_done[0] && lane_done[1]) && k < 60000) begin
         @(posedge clk);
         k++;
      end
      vectors++;
      if (!(lane_done[0] && lane_done[1])) begin
         miscompares++;
         $display("FAIL watchdog: lanes done=%0d%0d, required 11", lane_done[1], lane_done[0]);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
